// File: rtl/video_stream_pkg.sv
// video_stream_pkg: shared stream tag type, default raster size and test-pattern colours
package video_stream_pkg;
   typedef struct packed {
      logic valid;
      logic sop;
      logic eop;
   } pix_tag_t;
   localparam int DEF_H_RES = 320;
   localparam int DEF_V_RES = 240;
   // RGB10 colour bars {R,G,B}, index 0 is the leftmost bar
   localparam logic [7:0][29:0] CBAR_RGB10 = {
      30'h00000000, 30'h000003FF, 30'h3FF00000, 30'h3FF003FF,
      30'h000FFC00, 30'h000FFFFF, 30'h3FFFFC00, 30'h3FFFFFFF
   };
   // Synthetic pixel: 1 = colour bars, 2 = column ramp, 3 = 16x16 checkerboard
   function automatic logic [29:0] tp_pixel(input logic [1:0] sel, input int col, input int row, input int h_res);
      int bar;
      bar = (col * 8) / h_res;
      tp_pixel = sel == 2'd1 ? CBAR_RGB10[bar[2:0]] :
                 sel == 2'd2 ? 30'(col) :
                 ((col ^ row) & 16) != 0 ? '1 : '0;
   endfunction
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: small register FIFO that holds already-issued reads while the sink stalls
module stream_skid_fifo #(
   parameter int W = 32,
   parameter int D = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             push_data,
   output logic [W-1:0]             head_data,
   output logic [$clog2(D+1)-1:0]   count
);
   localparam int CW = $clog2(D + 1);
   localparam int PW = D > 1 ? $clog2(D) : 1;
   logic [W-1:0] mem [D];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(D - 1) ? '0 : p + 1'b1;
   endfunction
   assign do_pop = pop && count != '0;
   assign do_push = push && (count != CW'(D) || do_pop);
   assign head_data = mem[rd_ptr];
   // Storage needs no reset: the head is only looked at while count is non-zero
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   // Pointers and occupancy; flush empties the FIFO and drops a same-cycle push
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/frame_stream_gen.sv
// frame_stream_gen: raster reader turning a fixed-latency frame buffer into an Avalon-ST video packet stream
// Build macro FSG_TEST_PATTERN_EN adds tp_sel and synthetic test patterns in place of buffer data.
module frame_stream_gen
   import video_stream_pkg::*;
#(
   parameter int H_RES  = DEF_H_RES,
   parameter int V_RES  = DEF_V_RES,
   parameter int DATA_W = 30,
   parameter int ADDR_W = 17,
   parameter int RD_LAT = 1,
   parameter int FIFO_D = RD_LAT + 2
) (
`ifdef FSG_TEST_PATTERN_EN
   input  logic [1:0]        tp_sel,
`endif
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              restart,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [15:0]       frame_count,
   output logic              busy
);
   localparam int CW  = H_RES > 1 ? $clog2(H_RES) : 1;
   localparam int RW  = V_RES > 1 ? $clog2(V_RES) : 1;
   localparam int FCW = $clog2(FIFO_D + 1);
   localparam int FW  = DATA_W + 2;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   pix_tag_t tag_pipe [RD_LAT];
   logic [FCW-1:0] fifo_count;
   logic [FW-1:0] head;
   logic [DATA_W-1:0] cap_data;
   logic issue, last, xfer;
   int inflight;
   // Reads already issued but not yet captured, reserved against FIFO space
   always_comb begin
      inflight = 0;
      for (int i = 0; i < RD_LAT; i++) inflight += int'(tag_pipe[i].valid);
   end
   assign last = col == CW'(H_RES - 1) && row == RW'(V_RES - 1);
   assign issue = state == RUN && !restart && int'(fifo_count) + inflight < FIFO_D;
   assign out_valid = fifo_count != '0;
   assign xfer = out_valid && out_ready;
   assign out_data = out_valid ? head[DATA_W-1:0] : '0;
   assign out_sop = out_valid && head[DATA_W+1];
   assign out_eop = out_valid && head[DATA_W];
   assign busy = state == RUN || inflight != 0 || out_valid;
   // Raster walk, run/idle control, frame counting and the tag pipe that tracks each read
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         col <= '0;
         row <= '0;
         rd_addr <= '0;
         frame_count <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         if (xfer && out_eop) frame_count <= frame_count + 1'b1;
         if (restart) begin
            state <= enable ? RUN : IDLE;
            col <= '0;
            row <= '0;
            rd_addr <= '0;
         end else begin
            if (state == IDLE && enable) state <= RUN;
            if (issue) begin
               col <= col == CW'(H_RES - 1) ? '0 : col + 1'b1;
               row <= col != CW'(H_RES - 1) ? row : row == RW'(V_RES - 1) ? '0 : row + 1'b1;
               rd_addr <= last ? '0 : rd_addr + 1'b1;
               if (last && !enable) state <= IDLE;
            end
         end
         tag_pipe[0].valid <= issue;
         tag_pipe[0].sop <= issue && col == '0 && row == '0;
         tag_pipe[0].eop <= issue && last;
         for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= restart ? '0 : tag_pipe[i-1];
      end
`ifdef FSG_TEST_PATTERN_EN
   logic [DATA_W:0] pat_pipe [RD_LAT];
   // Synthetic pixel chosen at issue so it lands with the read it replaces
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) pat_pipe[i] <= '0;
      end else begin
         pat_pipe[0] <= {tp_sel != 2'd0, DATA_W'(tp_pixel(tp_sel, int'(col), int'(row), H_RES))};
         for (int i = 1; i < RD_LAT; i++) pat_pipe[i] <= pat_pipe[i-1];
      end
   assign cap_data = pat_pipe[RD_LAT-1][DATA_W] ? pat_pipe[RD_LAT-1][DATA_W-1:0] : rd_data;
`else
   assign cap_data = rd_data;
`endif
   stream_skid_fifo #(.W(FW), .D(FIFO_D)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (restart),
      .push      (tag_pipe[RD_LAT-1].valid),
      .pop       (xfer),
      .push_data ({tag_pipe[RD_LAT-1].sop, tag_pipe[RD_LAT-1].eop, cap_data}),
      .head_data (head),
      .count     (fifo_count)
   );
endmodule

// File: tb/tb_frame_stream_gen.sv
// tb_frame_stream_gen: directed bench for frame_stream_gen on a small 8x4 raster with a 3-cycle RAM
module tb_frame_stream_gen;
   localparam int H = 8, V = 4, N = H * V, L = 3, D = L + 2, DW = 30, AW = 5;
   logic clk = 1'b0, reset, enable, restart, out_ready, out_valid, out_sop, out_eop, busy;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, out_data;
   logic [15:0] frame_count;
`ifdef FSG_TEST_PATTERN_EN
   logic [1:0] tp_sel = 2'd0;
`endif
   logic [DW-1:0] ram_pipe [L];
   int errors = 0, checks = 0;
   int exp_idx = 0, xfers = 0, seq_err = 0, stab_err = 0, model_fc = 0;
   int cyc = 0, last_eop_cyc = 0, eop_gap = 0, n, fc0, x0, addr_err;
   bit after_rst = 0, got_first = 0, stall = 0, ovf = 0;
   logic [DW-1:0] first_data;
   logic first_sop;
   logic [DW+1:0] held;

   frame_stream_gen #(.H_RES(H), .V_RES(V), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(L), .FIFO_D(D)) dut (
`ifdef FSG_TEST_PATTERN_EN
      .tp_sel      (tp_sel),
`endif
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .restart     (restart),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .frame_count (frame_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // RAM model: word equals address, returned L cycles after the address is presented
   always @(posedge clk) begin
      ram_pipe[0] <= DW'(rd_addr);
      for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign rd_data = ram_pipe[L-1];

   always @(posedge clk)
      if (!reset) assert (int'(dut.fifo_count) <= D) else ovf = 1;

   function automatic logic [DW-1:0] exp_data(input int idx);
`ifdef FSG_TEST_PATTERN_EN
      if (tp_sel == 2'd2) return DW'(idx % H);
`endif
      return DW'(idx);
   endfunction

   // Stream scoreboard: expected raster index, stall stability and frame counting
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         exp_idx = 0;
         stall = 0;
      end else begin
         if (stall && (!out_valid || {out_sop, out_eop, out_data} !== held)) stab_err++;
         if (out_valid && out_ready) begin
            if (out_data !== exp_data(exp_idx) || out_sop !== (exp_idx == 0) || out_eop !== (exp_idx == N - 1)) seq_err++;
            if (after_rst) begin
               first_data = out_data;
               first_sop = out_sop;
               after_rst = 0;
               got_first = 1;
            end
            if (out_eop) begin
               model_fc++;
               eop_gap = cyc - last_eop_cyc;
               last_eop_cyc = cyc;
            end
            xfers++;
            exp_idx = (exp_idx + 1) % N;
         end
         if (restart) begin
            exp_idx = 0;
            after_rst = 1;
            got_first = 0;
         end
         stall = out_valid && !out_ready && !restart;
         held = {out_sop, out_eop, out_data};
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; enable = 0; restart = 0; out_ready = 0;
      repeat (2) tick();
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_sop", out_sop, 0);
      check("rst_eop", out_eop, 0);
      check("rst_data", out_data, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_busy", busy, 0);
      reset = 0;
      tick();
      // Start with the sink stalled: first-pixel latency, then credit-limited issue
      enable = 1;
      tick();
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      check("first_latency", n, L + 1);
      repeat (15) tick();
      check("stall_rd_addr", rd_addr, D);
      check("stall_valid", out_valid, 1);
      check("stall_sop", out_sop, 1);
      check("stall_data", out_data, 0);
      check("stall_busy", busy, 1);
      check("stall_no_xfer", xfers, 0);
      // Release: two full frames at one pixel per cycle
      out_ready = 1;
      n = 0;
      while (model_fc < 2 && n < 300) begin tick(); n++; end
      check("two_frames_fc", frame_count, 2);
      check("two_frames_xfers", xfers, 2 * N);
      check("two_frames_seq", seq_err, 0);
      check("frame_period", eop_gap, N);
      check("stall_stable", stab_err, 0);
      // Restart part way through frame 3
      n = 0;
      while (exp_idx != 20 && n < 200) begin tick(); n++; end
      check("reach_px20", exp_idx, 20);
      fc0 = model_fc;
      restart = 1;
      tick();
      restart = 0;
      n = 0;
      while (!got_first && n < 50) begin tick(); n++; end
      check("restart_seen", got_first, 1);
      check("restart_data", first_data, 0);
      check("restart_sop", first_sop, 1);
      check("restart_fc", frame_count, fc0);
      check("restart_seq", seq_err, 0);
      // Drop enable mid-frame: the frame completes, then the block idles
      n = 0;
      while (exp_idx != 10 && n < 200) begin tick(); n++; end
      check("reach_px10", exp_idx, 10);
      enable = 0;
      fc0 = model_fc;
      n = 0;
      while (model_fc == fc0 && n < 200) begin tick(); n++; end
      check("drain_eop", model_fc, fc0 + 1);
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      check("busy_fall", n <= L + D, 1);
      x0 = xfers;
      addr_err = 0;
      repeat (20) begin tick(); if (rd_addr != 0 || out_valid) addr_err++; end
      check("idle_quiet", addr_err, 0);
      check("idle_xfers", xfers, x0);
      check("idle_fc", frame_count, 16'(model_fc));
      check("idle_seq", seq_err, 0);
      // Random 30% sink duty
      enable = 1;
      repeat (300) begin
         out_ready = $urandom_range(0, 9) < 3;
         tick();
      end
      out_ready = 1;
      check("rand_progress", xfers > x0 + 50, 1);
      check("rand_seq", seq_err, 0);
      check("rand_stable", stab_err, 0);
      check("rand_no_overflow", ovf, 0);
      check("rand_fc", frame_count, 16'(model_fc));
`ifdef FSG_TEST_PATTERN_EN
      enable = 0;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      check("tp_idle", busy, 0);
      tp_sel = 2'd2;
      enable = 1;
      fc0 = model_fc;
      n = 0;
      while (model_fc == fc0 && n < 200) begin tick(); n++; end
      check("tp_frame", model_fc, fc0 + 1);
      check("tp_seq", seq_err, 0);
`endif
      // Asynchronous reset mid-frame
      n = 0;
      while (exp_idx != 5 && n < 200) begin tick(); n++; end
      check("reach_px5", exp_idx, 5);
      @(negedge clk);
      #2 reset = 1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_sop_eop", {out_sop, out_eop}, 0);
      check("arst_rd_addr", rd_addr, 0);
      check("arst_fc", frame_count, 0);
      check("arst_busy", busy, 0);
      tick();
      reset = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
